// File: rtl/sub_fmt_pkg.sv
// Shared types and default sizes for the subtractor result BCD formatter.
package sub_fmt_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;
  localparam int CNT_W_DEF  = 5;
  localparam int BCD_W      = 4 * DIGITS_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ABS   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } fmt_state_e;

endpackage

// File: rtl/sub_result_bcd_formatter_if.sv
// Handshake/result bundle between the subtractor, the BCD formatter and the readout.
// Optional macro SUB_BCD_OVERRUN_EN adds the sticky overrun flag.
interface sub_result_bcd_formatter_if #(
  parameter int WIDTH  = sub_fmt_pkg::WIDTH_DEF,
  parameter int DIGITS = sub_fmt_pkg::DIGITS_DEF
);

  logic                  in_valid;
  logic [WIDTH-1:0]      in_result;
  logic                  in_underflow;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  out_valid;
  logic                  busy;
`ifdef SUB_BCD_OVERRUN_EN
  logic                  overrun;

  modport master (output in_valid, in_result, in_underflow,
                  input  bcd, sign, out_valid, busy, overrun);
  modport slave  (input  in_valid, in_result, in_underflow,
                  output bcd, sign, out_valid, busy, overrun);
`else
  modport master (output in_valid, in_result, in_underflow,
                  input  bcd, sign, out_valid, busy);
  modport slave  (input  in_valid, in_result, in_underflow,
                  output bcd, sign, out_valid, busy);
`endif

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/sub_result_bcd_formatter.sv
// Converts the subtractor's signed difference to sign + packed BCD, one bit per clock.
// Optional macro SUB_BCD_OVERRUN_EN adds a sticky overrun flag for dropped inputs.
module sub_result_bcd_formatter
  import sub_fmt_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  sub_result_bcd_formatter_if.slave    fmt
);

  localparam int DIG_BITS = 4 * DIGITS;

  fmt_state_e           state_q, state_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 und_q, und_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic                 neg_q, neg_d;
  logic [DIG_BITS-1:0]  acc_q, acc_d;
  logic [DIG_BITS-1:0]  acc_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIG_BITS-1:0]  bcd_q, bcd_d;
  logic                 sign_q, sign_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (acc_q[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    und_d   = und_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (fmt.in_valid) begin
          res_d   = fmt.in_result;
          und_d   = fmt.in_underflow;
          state_d = ABS;
        end
      end
      ABS: begin
        mag_d   = und_q ? (~res_q + WIDTH'(1)) : res_q;
        // A zero difference flagged as underflow must not display as "-0".
        neg_d   = und_q && (res_q != '0);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {acc_d, mag_d} = {acc_adj, mag_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = acc_d;
          sign_d  = neg_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      und_q   <= 1'b0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      und_q   <= und_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
    end
  end

  assign fmt.bcd       = bcd_q;
  assign fmt.sign      = sign_q;
  assign fmt.out_valid = (state_q == DONE);
  assign fmt.busy      = (state_q != IDLE);

`ifdef SUB_BCD_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky until the next input is actually accepted.
  always_comb begin
    overrun_d = overrun_q;
    if (fmt.in_valid) begin
      overrun_d = (state_q != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign fmt.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_sub_result_bcd_formatter.sv
// Self-checking bench for sub_result_bcd_formatter (covers SUB_BCD_OVERRUN_EN when defined).
module tb_sub_result_bcd_formatter;
  import sub_fmt_pkg::*;

  localparam int LATENCY = 17;

  typedef struct packed {
    logic [15:0] result;
    logic        und;
    logic [19:0] exp_bcd;
    logic        exp_sign;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs [8];

  sub_result_bcd_formatter_if #(.WIDTH(16), .DIGITS(5)) fmt ();

  sub_result_bcd_formatter #(.WIDTH(16), .DIGITS(5), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .fmt   (fmt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge: pulse in_valid for one clock, then scramble the data lines.
  task automatic applyStimulus(input logic [15:0] result, input logic und);
    fmt.in_valid     = 1'b1;
    fmt.in_result    = result;
    fmt.in_underflow = und;
    @(negedge clk);
    fmt.in_valid     = 1'b0;
    fmt.in_result    = 16'($urandom);
    fmt.in_underflow = 1'($urandom);
  endtask

  // Reference: sign/magnitude by integer arithmetic, digits by repeated division.
  function automatic logic [20:0] refModel(input logic [15:0] result, input logic und);
    int unsigned mag;
    logic [19:0] bcd;
    mag = und ? ((32'd65536 - result) % 32'd65536) : result;
    bcd = '0;
    for (int d = 0; d < 5; d++) begin
      bcd[4*d +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    mag = und ? ((32'd65536 - result) % 32'd65536) : result;
    return {(und && mag != 0), bcd};
  endfunction

  task automatic runConversion(input string name, input logic [15:0] result, input logic und,
                               input logic [19:0] exp_bcd, input logic exp_sign);
    int cycles;
    applyStimulus(result, und);
    checkOutput({name, " busy"}, 32'(fmt.busy), 32'd1);
`ifdef SUB_BCD_OVERRUN_EN
    checkOutput({name, " overrun cleared"}, 32'(fmt.overrun), 32'd0);
`endif
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (fmt.out_valid) break;
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'(LATENCY));
    checkOutput({name, " bcd"}, 32'(fmt.bcd), 32'(exp_bcd));
    checkOutput({name, " sign"}, 32'(fmt.sign), 32'(exp_sign));
    @(negedge clk);
    checkOutput({name, " out_valid pulse"}, 32'(fmt.out_valid), 32'd0);
    checkOutput({name, " busy after"}, 32'(fmt.busy), 32'd0);
    checkOutput({name, " bcd hold"}, 32'(fmt.bcd), 32'(exp_bcd));
  endtask

  initial begin
    logic [20:0] exp;
    logic [15:0] r;
    logic        u;
    int          pulses;
    logic [19:0] seen_bcd;

    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    fmt.in_valid     = 1'b0;
    fmt.in_result    = '0;
    fmt.in_underflow = 1'b0;

    vecs[0] = '{16'h04D2, 1'b0, 20'h01234, 1'b0};
    vecs[1] = '{16'hFFFF, 1'b1, 20'h00001, 1'b1};
    vecs[2] = '{16'h0001, 1'b1, 20'h65535, 1'b1};
    vecs[3] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0};
    vecs[4] = '{16'h0000, 1'b1, 20'h00000, 1'b0};
    vecs[5] = '{16'h0000, 1'b0, 20'h00000, 1'b0};
    vecs[6] = '{16'h2710, 1'b0, 20'h10000, 1'b0};
    vecs[7] = '{16'hD8F0, 1'b1, 20'h10000, 1'b1};

    repeat (2) @(negedge clk);
    checkOutput("reset bcd", 32'(fmt.bcd), 32'd0);
    checkOutput("reset sign", 32'(fmt.sign), 32'd0);
    checkOutput("reset out_valid", 32'(fmt.out_valid), 32'd0);
    checkOutput("reset busy", 32'(fmt.busy), 32'd0);
`ifdef SUB_BCD_OVERRUN_EN
    checkOutput("reset overrun", 32'(fmt.overrun), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      runConversion($sformatf("vec%0d", i), vecs[i].result, vecs[i].und, vecs[i].exp_bcd, vecs[i].exp_sign);
    end

    // Second input arrives mid-conversion and must be dropped.
    applyStimulus(16'h0009, 1'b0);
    pulses   = 0;
    seen_bcd = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
`ifdef SUB_BCD_OVERRUN_EN
        checkOutput("overrun before drop", 32'(fmt.overrun), 32'd0);
`endif
        fmt.in_valid     = 1'b1;
        fmt.in_result    = 16'h0007;
        fmt.in_underflow = 1'b0;
      end
      @(negedge clk);
      fmt.in_valid = 1'b0;
      if (fmt.out_valid) begin
        pulses++;
        seen_bcd = fmt.bcd;
        checkOutput("drop latency", 32'(c), 32'(LATENCY));
      end
    end
    checkOutput("drop pulse count", 32'(pulses), 32'd1);
    checkOutput("drop bcd", 32'(seen_bcd), 32'h00009);
`ifdef SUB_BCD_OVERRUN_EN
    checkOutput("overrun sticky", 32'(fmt.overrun), 32'd1);
`endif
    runConversion("after drop", 16'h0007, 1'b0, 20'h00007, 1'b0);

    // Reset mid-conversion after a negative result is on the outputs.
    runConversion("pre reset", 16'hFFFF, 1'b1, 20'h00001, 1'b1);
    applyStimulus(16'h0001, 1'b1);
    repeat (2) @(negedge clk);
    fmt.in_valid = 1'b1;
    @(negedge clk);
    fmt.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid busy", 32'(fmt.busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort bcd", 32'(fmt.bcd), 32'd0);
    checkOutput("abort sign", 32'(fmt.sign), 32'd0);
    checkOutput("abort out_valid", 32'(fmt.out_valid), 32'd0);
    checkOutput("abort busy", 32'(fmt.busy), 32'd0);
`ifdef SUB_BCD_OVERRUN_EN
    checkOutput("abort overrun", 32'(fmt.overrun), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    runConversion("post reset", 16'h0064, 1'b0, 20'h00100, 1'b0);

    // Randomized back-to-back conversions against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      r   = 16'($urandom_range(0, 65535));
      u   = 1'($urandom_range(0, 1));
      exp = refModel(r, u);
      runConversion($sformatf("rand%0d", i), r, u, exp[19:0], exp[20]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub_result_bcd_formatter.md
Name: sub_result_bcd_formatter

Overview:
- Downstream stage of the 16-bit sequential subtractor.
- Consumes the subtractor's result, underflow and done pulse. Converts the signed difference to sign plus magnitude, then to packed BCD using a sequential double-dabble (shift-add-3), one bit per clock.
- Feeds the display/readout logic.

Parameters:
- WIDTH, 16, operand width; must match the subtractor result width.
- DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH - 1.
- CNT_W, 5, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  one-cycle pulse; connects to the subtractor's done.
- in_result  in  WIDTH  difference a-b modulo 2^WIDTH.
- in_underflow  in  1  1 = a<b, difference is negative.
- bcd  out  4*DIGITS  packed BCD magnitude; digit 0 in bits [3:0].
- sign  out  1  1 = negative result.
- out_valid  out  1  one-cycle pulse; bcd and sign are valid.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (reset=0, async): state IDLE; bcd=0, sign=0, out_valid=0, busy=0; all internal registers 0.
- Registered FSM states:
  - IDLE: in_valid=1 latches in_result and in_underflow, goes to ABS.
  - ABS: mag = in_underflow ? (~in_result + 1) mod 2^WIDTH : in_result. Clears the BCD accumulator and counter, goes to SHIFT.
  - SHIFT: each cycle, every BCD digit >= 5 gets +3; then {acc, mag} shifts left 1. Counter increments. After the WIDTH-th iteration, goes to DONE.
  - DONE: out_valid=1 for exactly one cycle, then IDLE.
- On the edge entering DONE, bcd and sign load together. They hold until the next conversion loads or until reset.
- Latency: the edge sampling in_valid is edge 0. out_valid is high in the cycle after edge WIDTH+1 (edge 17 at defaults).
- Throughput: one conversion per WIDTH+3 cycles.
- busy=1 in ABS, SHIFT and DONE; 0 in IDLE.
- in_valid while busy is ignored. The in-flight conversion is unaffected and no queueing occurs.
- Negative zero: sign = in_underflow AND (mag != 0). An input of result=0 with underflow=1 yields sign=0, bcd=0.
- Largest magnitude 65535 (result=0x0001, underflow=1) must convert exactly. No digit may exceed 9 at any step.
- Reset asserted mid-conversion aborts immediately and all outputs return to reset values. The first in_valid after reset release converts correctly.
- in_result and in_underflow are sampled only on the accepting edge; later changes have no effect.

Optional Feature:
- Macro: SUB_BCD_OVERRUN_EN.
- Defined:
  - Adds output port overrun (1 bit), reset value 0.
  - overrun sets when in_valid=1 while busy=1, and stays set.
  - It clears only when in_valid is accepted in IDLE; that same edge clears it.
  - The dropped input is still ignored.
- Not defined: no overrun port or logic; behaviour otherwise identical.

Decomposition:
- Shared package sub_fmt_pkg:
  - State encoding localparams: IDLE=2'b00, ABS=2'b01, SHIFT=2'b10, DONE=2'b11.
  - Default WIDTH/DIGITS constants.
  - BCD_W = 4*DIGITS.
- Sub-module bcd_digit_adjust: combinational, 4-bit in and out; adds 3 when the input is >= 5. Instantiated DIGITS times in a generate loop.
- FSM, counter and shift datapath stay in the top module.

Test Plan:
- in_result=0x04D2 (1234), in_underflow=0 -> 17 cycles later out_valid=1 for 1 cycle, bcd=0x01234, sign=0, busy low the cycle after.
- in_result=0xFFFF, in_underflow=1 (0-1) -> bcd=0x00001, sign=1.
- in_result=0x0001, in_underflow=1 (0-65535) -> bcd=0x65535, sign=1. Separately, in_result=0xFFFF, in_underflow=0 -> bcd=0x65535, sign=0.
- in_result=0x0000, in_underflow=1 -> bcd=0x00000, sign=0.
- Start with 0x0009/0; pulse in_valid with 0x0007/0 at edge 5 -> only one out_valid, bcd=0x00009. With SUB_BCD_OVERRUN_EN, overrun=1 until the next accepted in_valid.
- Assert reset during SHIFT (edge 8) -> bcd=0, sign=0, out_valid=0, busy=0 immediately. Release and send 0x0064/0 -> bcd=0x00100.
